// File: rtl/fetch_request_unit_if.sv
// Fetch-address, I-cache request/response and fetch-group output signals of the fetch request unit.
// The master modport is the fetch request unit; the slave modport is its surrounding environment.
interface fetch_request_unit_if;
    logic        flush;
    logic [31:0] pc;
    logic        ready;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic [63:0] ic_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_vaddr;
    logic [63:0] out_instr;
    logic [1:0]  out_mask;

    modport master (
        input  flush, pc, ic_gnt, ic_rvalid, ic_rdata, out_ready,
        output ready, ic_req, ic_addr, out_valid, out_vaddr, out_instr, out_mask
    );

    modport slave (
        output flush, pc, ic_gnt, ic_rvalid, ic_rdata, out_ready,
        input  ready, ic_req, ic_addr, out_valid, out_vaddr, out_instr, out_mask
    );
endinterface

// File: rtl/fetch_request_unit.sv
// Issues aligned I-cache fetches, tracks them in order, drops flushed responses, and queues 2-instruction groups.
// Latency: response cycle + 1 to out_valid. Issue stops when the in-flight/queued credit runs out. Perf counters are built only with FETCH_PERF_CNT_EN.
module fetch_request_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_request_unit_if.master  fif,
    output logic [CNT_W-1:0]      perf_drop,
    output logic [CNT_W-1:0]      perf_stall
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] cnt_t;
    typedef logic [PW+1:0] sum_t;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [63:0] instr;
        logic [1:0]  mask;
    } grp_t;

    logic [31:0]   pend_mem [DEPTH];
    logic [PW-1:0] pend_wp, pend_rp;
    cnt_t          pend_cnt;

    grp_t          out_mem [DEPTH];
    logic [PW-1:0] out_wp, out_rp;
    cnt_t          out_cnt;

    cnt_t          drop_cnt;

    sum_t          sum_po, sum_pd;
    logic          credit_ok, issue, grant;
    logic          rsp_drop, rsp_take, push_out, pop_out;
    logic [31:0]   head_vaddr;
    cnt_t          flush_drop;
    grp_t          out_head;

    assign sum_po    = {1'b0, pend_cnt} + {1'b0, out_cnt};
    assign sum_pd    = {1'b0, pend_cnt} + {1'b0, drop_cnt};
    assign credit_ok = (sum_po < sum_t'(DEPTH)) && (sum_pd < sum_t'(DEPTH));

    assign issue       = ~rst & ~fif.flush & credit_ok;
    assign grant       = issue & fif.ic_gnt;
    assign fif.ic_req  = issue;
    assign fif.ready   = grant;
    assign fif.ic_addr = {fif.pc[31:3], 3'b000};

    assign head_vaddr = pend_mem[pend_rp];
    assign rsp_drop   = fif.ic_rvalid & (drop_cnt != '0);
    // A response with nothing pending and nothing to drop is a protocol error and is ignored.
    assign rsp_take   = fif.ic_rvalid & (drop_cnt == '0) & (pend_cnt != '0);
    assign push_out   = rsp_take & ~fif.flush;
    assign pop_out    = fif.out_valid & fif.out_ready;

    // Every pending request becomes stale on flush; a response arriving that same cycle retires one of them.
    assign flush_drop = cnt_t'(sum_pd - sum_t'(fif.ic_rvalid && (sum_pd != '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wp  <= '0;
            pend_rp  <= '0;
            pend_cnt <= '0;
            out_wp   <= '0;
            out_rp   <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (fif.flush) begin
            pend_wp  <= '0;
            pend_rp  <= '0;
            pend_cnt <= '0;
            out_wp   <= '0;
            out_rp   <= '0;
            out_cnt  <= '0;
            drop_cnt <= flush_drop;
        end else begin
            if (grant)    pend_wp <= pend_wp + PW'(1);
            if (rsp_take) pend_rp <= pend_rp + PW'(1);
            pend_cnt <= pend_cnt + cnt_t'(grant) - cnt_t'(rsp_take);
            if (push_out) out_wp <= out_wp + PW'(1);
            if (pop_out)  out_rp <= out_rp + PW'(1);
            out_cnt <= out_cnt + cnt_t'(push_out) - cnt_t'(pop_out);
            if (rsp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant)    pend_mem[pend_wp] <= fif.pc;
        if (push_out) out_mem[out_wp]   <= '{vaddr: head_vaddr,
                                             instr: fif.ic_rdata,
                                             mask:  head_vaddr[2] ? 2'b10 : 2'b11};
    end

    assign out_head      = out_mem[out_rp];
    assign fif.out_valid = (out_cnt != '0);
    assign fif.out_vaddr = fif.out_valid ? out_head.vaddr : '0;
    assign fif.out_instr = fif.out_valid ? out_head.instr : '0;
    assign fif.out_mask  = fif.out_valid ? out_head.mask  : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] drop_q, stall_q;
    logic             stale_evt, stall_evt;

    assign stale_evt = fif.ic_rvalid & ((drop_cnt != '0) | (fif.flush & (pend_cnt != '0)));
    assign stall_evt = ~fif.flush & ~credit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q  <= '0;
            stall_q <= '0;
        end else begin
            if (stale_evt && drop_q != '1)  drop_q  <= drop_q + CNT_W'(1);
            if (stall_evt && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign perf_drop  = drop_q;
    assign perf_stall = stall_q;
`else
    assign perf_drop  = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_fetch_request_unit.sv
// Bench for fetch_request_unit: directed vector table, hand-written flush corner cases, then random traffic against a queue model.
module tb_fetch_request_unit;
    localparam int DEPTH = 4;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_drop, perf_stall;
    int          checks = 0;
    int          errors = 0;

    fetch_request_unit_if fif ();

    fetch_request_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fif(fif), .perf_drop(perf_drop), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [63:0] in;
        logic [1:0]  mk;
    } grp_t;

    logic [31:0] m_pend[$];
    grp_t        m_out[$];
    int unsigned m_drop = 0, m_pdrop = 0, m_pstall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic f, input logic [31:0] p, input logic g,
                          input logic v, input logic [63:0] d, input logic o);
        rst = r; fif.flush = f; fif.pc = p; fif.ic_gnt = g;
        fif.ic_rvalid = v; fif.ic_rdata = d; fif.out_ready = o;
    endtask

    function automatic bit m_credit();
        return (m_pend.size() + m_out.size() < DEPTH) && (m_pend.size() + m_drop < DEPTH);
    endfunction

    // Compare DUT outputs against the model's view of the current cycle.
    task automatic sample();
        bit e_req;
        @(negedge clk);
        e_req = !rst && !fif.flush && m_credit();
        chk("m_ic_req", fif.ic_req, e_req);
        chk("m_ready", fif.ready, e_req && fif.ic_gnt);
        chk("m_ic_addr", fif.ic_addr, {fif.pc[31:3], 3'b000});
        chk("m_out_valid", fif.out_valid, m_out.size() > 0);
        if (m_out.size() > 0) begin
            chk("m_out_vaddr", fif.out_vaddr, m_out[0].va);
            chk("m_out_instr", fif.out_instr, m_out[0].in);
            chk("m_out_mask", fif.out_mask, m_out[0].mk);
        end
        chk("m_perf_drop", perf_drop, PERF ? m_pdrop : 0);
        chk("m_perf_stall", perf_stall, PERF ? m_pstall : 0);
    endtask

    task automatic model_update();
        int unsigned np = m_pend.size();
        bit credit = m_credit();
        grp_t g;
        if (rst) begin
            m_pend.delete(); m_out.delete();
            m_drop = 0; m_pdrop = 0; m_pstall = 0;
            return;
        end
        if (!fif.flush && !credit && m_pstall != 32'hFFFF_FFFF) m_pstall++;
        if (fif.flush) begin
            if (fif.ic_rvalid && (np + m_drop) > 0) begin
                m_drop = m_drop + np - 1;
                m_pdrop++;
            end else begin
                m_drop = m_drop + np;
            end
            m_pend.delete(); m_out.delete();
        end else begin
            if (m_out.size() > 0 && fif.out_ready) void'(m_out.pop_front());
            if (fif.ic_rvalid) begin
                if (m_drop > 0) begin
                    m_drop--;
                    m_pdrop++;
                end else if (np > 0) begin
                    g.va = m_pend.pop_front();
                    g.in = fif.ic_rdata;
                    g.mk = g.va[2] ? 2'b10 : 2'b11;
                    m_out.push_back(g);
                end
            end
            if (credit && fif.ic_gnt) m_pend.push_back(fif.pc);
        end
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst, flush;
        logic [31:0] pc;
        logic        gnt, rv;
        logic [63:0] rd;
        logic        ordy;
        logic        e_rdy, e_req, e_ov;
        logic [31:0] e_addr, e_va;
        logic [63:0] e_in;
        logic [1:0]  e_mk;
    } vec_t;

    function automatic vec_t mkv(logic r, logic [31:0] p, logic g, logic v, logic [63:0] d, logic o,
                                 logic er, logic eq, logic eo, logic [31:0] ea, logic [31:0] eva,
                                 logic [63:0] ein, logic [1:0] emk);
        vec_t t;
        t.rst = r; t.flush = 1'b0; t.pc = p; t.gnt = g; t.rv = v; t.rd = d; t.ordy = o;
        t.e_rdy = er; t.e_req = eq; t.e_ov = eo; t.e_addr = ea; t.e_va = eva; t.e_in = ein; t.e_mk = emk;
        return t;
    endfunction

    localparam logic [63:0] D0 = 64'h11111111_22222222;
    localparam logic [63:0] D1 = 64'h33333333_44444444;
    localparam logic [63:0] E0 = 64'hC0DE0000_00001000;
    localparam logic [63:0] E1 = 64'hC0DE0000_00001008;

    vec_t tbl[17];

    initial begin
        tbl[0]  = mkv(1, 32'hBFC00000, 1, 0, 64'h0, 0, 0, 0, 0, 32'hBFC00000, 32'h0, 64'h0, 2'b00);
        tbl[1]  = mkv(0, 32'hBFC00000, 1, 0, 64'h0, 0, 1, 1, 0, 32'hBFC00000, 32'h0, 64'h0, 2'b00);
        tbl[2]  = mkv(0, 32'hBFC00000, 0, 1, D0,    0, 0, 1, 0, 32'hBFC00000, 32'h0, 64'h0, 2'b00);
        tbl[3]  = mkv(0, 32'hBFC00000, 0, 0, 64'h0, 1, 0, 1, 1, 32'hBFC00000, 32'hBFC00000, D0, 2'b11);
        tbl[4]  = mkv(0, 32'h80000004, 1, 0, 64'h0, 0, 1, 1, 0, 32'h80000000, 32'h0, 64'h0, 2'b00);
        tbl[5]  = mkv(0, 32'h80000004, 0, 1, D1,    0, 0, 1, 0, 32'h80000000, 32'h0, 64'h0, 2'b00);
        tbl[6]  = mkv(0, 32'h80000004, 0, 0, 64'h0, 0, 0, 1, 1, 32'h80000000, 32'h80000004, D1, 2'b10);
        tbl[7]  = mkv(0, 32'h80000004, 0, 0, 64'h0, 1, 0, 1, 1, 32'h80000000, 32'h80000004, D1, 2'b10);
        tbl[8]  = mkv(0, 32'h00001000, 1, 0, 64'h0, 0, 1, 1, 0, 32'h00001000, 32'h0, 64'h0, 2'b00);
        tbl[9]  = mkv(0, 32'h00001008, 1, 1, E0,    0, 1, 1, 0, 32'h00001008, 32'h0, 64'h0, 2'b00);
        tbl[10] = mkv(0, 32'h00001010, 1, 1, E1,    0, 1, 1, 1, 32'h00001010, 32'h1000, E0, 2'b11);
        tbl[11] = mkv(0, 32'h00001018, 1, 1, 64'h2, 0, 1, 1, 1, 32'h00001018, 32'h1000, E0, 2'b11);
        tbl[12] = mkv(0, 32'h00001020, 1, 1, 64'h3, 0, 0, 0, 1, 32'h00001020, 32'h1000, E0, 2'b11);
        tbl[13] = mkv(0, 32'h00001020, 1, 0, 64'h0, 0, 0, 0, 1, 32'h00001020, 32'h1000, E0, 2'b11);
        tbl[14] = mkv(0, 32'h00001020, 1, 0, 64'h0, 1, 0, 0, 1, 32'h00001020, 32'h1000, E0, 2'b11);
        tbl[15] = mkv(0, 32'h00001020, 1, 0, 64'h0, 0, 1, 1, 1, 32'h00001020, 32'h1008, E1, 2'b11);
        tbl[16] = mkv(0, 32'h00001028, 1, 0, 64'h0, 0, 0, 0, 1, 32'h00001028, 32'h1008, E1, 2'b11);

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].rst, tbl[i].flush, tbl[i].pc, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].ordy);
            sample();
            chk($sformatf("v%0d_ready", i), fif.ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_ic_req", i), fif.ic_req, tbl[i].e_req);
            chk($sformatf("v%0d_ic_addr", i), fif.ic_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_out_valid", i), fif.out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov || tbl[i].rst) begin
                chk($sformatf("v%0d_out_vaddr", i), fif.out_vaddr, tbl[i].e_va);
                chk($sformatf("v%0d_out_instr", i), fif.out_instr, tbl[i].e_in);
                chk($sformatf("v%0d_out_mask", i), fif.out_mask, tbl[i].e_mk);
            end
            advance();
        end

        // Flush with three requests outstanding: their responses must all be discarded.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 32'h2000 + 32'(8 * i), 1, 0, 64'h0, 0);
            cyc();
        end
        set_in(0, 1, 32'h2018, 1, 0, 64'h0, 0);
        sample();
        chk("a_flush_ready", fif.ready, 1'b0);
        chk("a_flush_req", fif.ic_req, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 32'h2018, 0, 1, 64'hDEAD0000 + 64'(i), 0);
            sample();
            chk("a_stale_out_valid", fif.out_valid, 1'b0);
            advance();
        end
        set_in(0, 0, 32'h80001000, 1, 0, 64'h0, 0);
        sample();
        chk("a_new_ready", fif.ready, 1'b1);
        advance();
        set_in(0, 0, 32'h80001008, 0, 1, 64'hAAAA, 0);
        sample();
        chk("a_pre_out_valid", fif.out_valid, 1'b0);
        advance();
        set_in(0, 0, 32'h80001008, 0, 0, 64'h0, 1);
        sample();
        chk("a_out_valid", fif.out_valid, 1'b1);
        chk("a_out_vaddr", fif.out_vaddr, 32'h80001000);
        chk("a_out_instr", fif.out_instr, 64'hAAAA);
        chk("a_out_mask", fif.out_mask, 2'b11);
        chk("a_perf_drop", perf_drop, PERF ? 32'd3 : 32'd0);
        advance();
        set_in(0, 0, 32'h80001008, 0, 0, 64'h0, 0);
        sample();
        chk("a_drained", fif.out_valid, 1'b0);
        advance();

        // Flush coinciding with a response while two are pending: one more response is dropped.
        do_reset();
        set_in(0, 0, 32'h3000, 1, 0, 64'h0, 0); cyc();
        set_in(0, 0, 32'h3008, 1, 0, 64'h0, 0); cyc();
        set_in(0, 1, 32'h3010, 1, 1, 64'h5151, 0);
        sample();
        chk("b_flush_ready", fif.ready, 1'b0);
        advance();
        set_in(0, 0, 32'h3010, 0, 1, 64'h5252, 0);
        sample();
        chk("b_out_valid0", fif.out_valid, 1'b0);
        advance();
        set_in(0, 0, 32'h3010, 0, 0, 64'h0, 0);
        sample();
        chk("b_out_valid1", fif.out_valid, 1'b0);
        chk("b_req_resumes", fif.ic_req, 1'b1);
        chk("b_perf_drop", perf_drop, PERF ? 32'd2 : 32'd0);
        advance();

        // Flush concurrent with an output pop and a grant.
        do_reset();
        set_in(0, 0, 32'h4000, 1, 0, 64'h0, 0); cyc();
        set_in(0, 0, 32'h4008, 0, 1, 64'h7777, 0); cyc();
        set_in(0, 1, 32'h4008, 1, 0, 64'h0, 1);
        sample();
        chk("c_out_valid_before", fif.out_valid, 1'b1);
        chk("c_flush_ready", fif.ready, 1'b0);
        chk("c_flush_req", fif.ic_req, 1'b0);
        advance();
        set_in(0, 0, 32'h4008, 0, 0, 64'h0, 0);
        sample();
        chk("c_out_valid_after", fif.out_valid, 1'b0);
        advance();

        // Random traffic against the queue model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic r, f, g, v, o;
            r = ($urandom_range(0, 299) == 0);
            f = ($urandom_range(0, 24) == 0);
            g = ($urandom_range(0, 2) != 0);
            v = !r && (m_pend.size() + m_drop > 0) && ($urandom_range(0, 1) == 1);
            o = ($urandom_range(0, 2) != 0);
            set_in(r, f, $urandom(), g, v, {$urandom(), $urandom()}, o);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_request_unit.md
Name: fetch_request_unit

Overview:
- Consumer side of the fetch-address interface. Accepts the current fetch PC from the PC generator and drives back `ready`.
- Issues 8-byte-aligned fetch requests to the I-cache and tracks in-flight requests in order.
- Discards responses made stale by a redirect/flush.
- Delivers 2-instruction fetch groups, with a valid mask, to the instruction buffer.

Parameters:
- DEPTH, 4, maximum in-flight requests plus queued output groups (credit limit); power of 2, ≥2.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  redirect (exception/replay/mispredict); kills all in-flight and queued groups
- pc  in  32  current fetch PC from the PC generator
- ready  out  1  fetch PC accepted this cycle; PC generator advances on it
- ic_req  out  1  I-cache request valid
- ic_addr  out  32  request address = {pc[31:3],3'b000}
- ic_gnt  in  1  I-cache accepts request this cycle
- ic_rvalid  in  1  I-cache response valid (in order, 1 per granted request)
- ic_rdata  in  64  response data; [31:0] = word at +0, [63:32] = word at +4
- out_valid  out  1  fetch group available
- out_ready  in  1  instruction buffer consumes group
- out_vaddr  out  32  PC of the group (unaligned original pc)
- out_instr  out  64  instruction pair
- out_mask  out  2  bit0 = word +0 valid, bit1 = word +4 valid
- perf_drop  out  CNT_W  dropped stale responses (optional feature)
- perf_stall  out  CNT_W  cycles with ic_req low due to credit (optional feature)

Behaviour:
State:
- Pending FIFO (DEPTH entries of vaddr) holds granted, unanswered requests.
- Output FIFO (DEPTH entries of {vaddr,instr,mask}).
- drop_cnt (log2(DEPTH)+1 bits) counts outstanding stale responses.
- credit_ok = (pend_cnt + out_cnt < DEPTH) && (pend_cnt + drop_cnt < DEPTH).

Request issue (combinational):
- ic_req = ~rst & ~flush & credit_ok.
- ic_addr = {pc[31:3],3'b0}.
- ready = ic_req & ic_gnt; the same cycle, pc is pushed into the pending FIFO.

Response handling:
- If ic_rvalid & drop_cnt≠0: decrement drop_cnt; data discarded.
- Else if ic_rvalid: pop the pending head and push {head_vaddr, ic_rdata, head_vaddr[2] ? 2'b10 : 2'b11} into the output FIFO.
- ic_rvalid with pend_cnt=0 and drop_cnt=0 is a protocol error; ignore it.
- Responses arrive no earlier than the cycle after grant.

Output:
- out_* reflect the output FIFO head (registered storage, no combinational path from ic_rdata).
- Pop on out_valid & out_ready.

Flush (takes priority over all same-cycle events):
- Output FIFO cleared.
- Pending FIFO cleared.
- drop_cnt ← drop_cnt + pend_cnt − (ic_rvalid ? 1 : 0).
- No request is issued, ready=0, and the output pop is ignored.
- The cycle after flush, issue resumes if credit_ok.

Simultaneous push/pop on either FIFO in one cycle: count unchanged; pointers wrap modulo DEPTH.

Reset:
- ready=0, ic_req=0, out_valid=0, out_vaddr=0, out_instr=0, out_mask=0, perf_*=0.
- FIFOs emptied, drop_cnt=0.
- Reset mid-operation: in-flight cache responses are the cache's responsibility; the cache is reset with the same rst.

Latency: grant at cycle N, response at N+k gives out_valid at N+k+1.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - perf_drop increments on each discarded stale response.
  - perf_stall increments on each non-reset, non-flush cycle with credit_ok=0.
  - Both saturate at all-ones; both clear on rst.
- Not defined: perf_drop and perf_stall tied to 0, no counter flops.

Test Plan:
- Reset release, ic_gnt=1, pc=0xBFC00000, response 1 cycle later with rdata=0x11111111_22222222 → ready=1 at cycle 0; out_valid at cycle 2 with vaddr=0xBFC00000, instr=0x1111111122222222, mask=2'b11.
- pc=0x80000004 (pc[2]=1) granted and answered → ic_addr=0x80000000, out_mask=2'b10, out_vaddr=0x80000004.
- out_ready=0, ic_gnt=1, immediate responses, DEPTH=4 → exactly 4 grants, then ic_req=0 and ready=0; one out_ready pulse → one further grant the next cycle.
- 3 grants outstanding, flush, then 3 responses with distinct data, then a new grant at 0x80001000 answered with 0xAAAA → first 3 responses dropped (perf_drop=3 with macro); only the 0x80001000 group appears.
- flush in the same cycle as ic_rvalid with 2 pending → drop_cnt=1; the next response is dropped; out_valid stays 0.
- flush concurrent with out_valid & out_ready and ic_gnt=1 → ready=0, no push, output FIFO empty next cycle.
